// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared encodings for the LED pattern sequencer: LED width,
//               mode codes, FSM state codes and the initial pattern per mode.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

  localparam int LED_W = 16;

  // Mode codes as written by game logic
  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_SCROLL = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_BAR    = 2'd3;

  // Sequencer states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_LOAD = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_KICK = 3'd4;

  // Pattern loaded when a mode is accepted
  localparam logic [LED_W-1:0] INIT_OFF    = 16'h0000;
  localparam logic [LED_W-1:0] INIT_SCROLL = 16'h0001;
  localparam logic [LED_W-1:0] INIT_BLINK  = 16'hFFFF;
  localparam logic [LED_W-1:0] INIT_BAR    = 16'h0001;

  function automatic logic [LED_W-1:0] init_pattern(input logic [1:0] m);
    logic [LED_W-1:0] r;
    case (m)
      MODE_SCROLL: r = INIT_SCROLL;
      MODE_BLINK:  r = INIT_BLINK;
      MODE_BAR:    r = INIT_BAR;
      default:     r = INIT_OFF;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_div.sv
`default_nettype none
// ============================================================================
// Module      : led_tick_div
// Description : Pattern-step timebase. Counts 0..TICK_DIV-1, wraps, and flags
//               the terminal count for one cycle. A clear restarts from 0.
// Revision    : 1.0 - initial release
// ============================================================================
module led_tick_div #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [31:0] LAST = 32'(TICK_DIV - 1);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Next count: clear wins over wrap, wrap at the terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/led_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_seq
// Description : Generates timed 16-bit LED patterns for the GPIO output stage.
//               Each step issues one EN (latch) pulse followed LAT_GAP cycles
//               later by one Start (serialize) pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_seq
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned LAT_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_we_i,
  input  logic [1:0]  mode_i,
  input  logic        freeze_i,
  output logic [31:0] p_data_o,
  output logic        en_o,
  output logic        start_o,
  output logic [1:0]  cur_mode_o
);

  // GAP holds for LAT_GAP-1 cycles; with LAT_GAP==1 LOAD goes straight to KICK
  localparam bit          HAS_GAP  = (LAT_GAP > 1);
  localparam logic [31:0] GAP_LAST = (LAT_GAP > 1) ? 32'(LAT_GAP - 2) : 32'd0;

  logic [2:0]       state_q,     state_d;
  logic [1:0]       cur_mode_q,  cur_mode_d;
  logic [LED_W-1:0] pattern_q,   pattern_d;
  logic [LED_W-1:0] p_data_q,    p_data_d;
  logic             pend_q,      pend_d;
  logic [1:0]       pend_mode_q, pend_mode_d;
  logic [31:0]      gap_cnt_q,   gap_cnt_d;

  logic             w_tick;
  logic             w_can_accept;
  logic             w_accept;
  logic [1:0]       w_wr_mode;
  logic [LED_W-1:0] w_next_pat;

  // A write strobe in an accepting state is taken the same cycle, so the
  // first en follows one cycle later; otherwise it parks in the pending slot.
  assign w_can_accept = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign w_accept     = w_can_accept && (pend_q || mode_we_i);
  assign w_wr_mode    = mode_we_i ? mode_i : pend_mode_q;

  led_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (w_accept),
    .tick_o (w_tick)
  );

  // Next pattern for the active mode
  always_comb begin
    w_next_pat = '0;
    case (cur_mode_q)
      MODE_SCROLL: w_next_pat = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
      MODE_BLINK:  w_next_pat = ~pattern_q;
      MODE_BAR:    w_next_pat = (pattern_q == '1) ? '0 : {pattern_q[LED_W-2:0], 1'b1};
      default:     w_next_pat = '0;
    endcase
  end

  // Sequencer next-state: acceptance beats a tick, ticks outside RUN are lost
  always_comb begin
    state_d     = state_q;
    cur_mode_d  = cur_mode_q;
    pattern_d   = pattern_q;
    p_data_d    = p_data_q;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    gap_cnt_d   = gap_cnt_q;

    if (mode_we_i) begin
      pend_d      = 1'b1;
      pend_mode_d = mode_i;
    end

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (w_accept) begin
          cur_mode_d = w_wr_mode;
          pattern_d  = init_pattern(w_wr_mode);
          pend_d     = 1'b0;
          state_d    = ST_LOAD;
        end else if ((state_q == ST_RUN) && w_tick && !freeze_i) begin
          pattern_d = w_next_pat;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        p_data_d  = pattern_q;
        gap_cnt_d = '0;
        state_d   = HAS_GAP ? ST_GAP : ST_KICK;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_KICK;
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end
      ST_KICK: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset aborts any sequence in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_mode_q  <= MODE_OFF;
      pattern_q   <= '0;
      p_data_q    <= '0;
      pend_q      <= 1'b0;
      pend_mode_q <= MODE_OFF;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_mode_q  <= cur_mode_d;
      pattern_q   <= pattern_d;
      p_data_q    <= p_data_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign p_data_o   = {{(32-LED_W){1'b0}}, p_data_q};
  assign en_o       = (state_q == ST_LOAD);
  assign start_o    = (state_q == ST_KICK);
  assign cur_mode_o = cur_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_seq
// Description : Self-checking bench for led_pattern_seq (TICK_DIV=4,
//               LAT_GAP=2). A timeline model predicts every output each cycle;
//               directed steps pin pattern values and latencies with literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_seq;

  localparam int TICK_DIV = 4;
  localparam int LAT_GAP  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode_we_i;
  logic [1:0]  mode_i;
  logic        freeze_i;
  logic [31:0] p_data_o;
  logic        en_o;
  logic        start_o;
  logic [1:0]  cur_mode_o;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int start_cnt = 0;

  led_pattern_seq #(
    .TICK_DIV (TICK_DIV),
    .LAT_GAP  (LAT_GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_we_i  (mode_we_i),
    .mode_i     (mode_i),
    .freeze_i   (freeze_i),
    .p_data_o   (p_data_o),
    .en_o       (en_o),
    .start_o    (start_o),
    .cur_mode_o (cur_mode_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] init_of(input logic [1:0] m);
    case (m)
      2'd1:    return 16'h0001;
      2'd2:    return 16'hFFFF;
      2'd3:    return 16'h0001;
      default: return 16'h0000;
    endcase
  endfunction

  // Pattern rules in arithmetic form
  function automatic logic [15:0] next_of(input logic [1:0] m, input logic [15:0] p);
    int v;
    v = int'(p);
    case (m)
      2'd1:    return 16'(((v * 2) + (v / 32768)) % 65536);
      2'd2:    return 16'(65535 - v);
      2'd3:    return (v == 65535) ? 16'h0000 : 16'(((v * 2) + 1) % 65536);
      default: return 16'h0000;
    endcase
  endfunction

  // Timeline model: each step is an en at a known cycle, start LAT_GAP later,
  // the new pattern visible the cycle after en; ticks every TICK_DIV cycles
  // counted from the last counter restart.
  initial begin : compare
    longint     cyc, m_en, m_cnt0;
    bit         m_act, m_pend, free, tick, exp_en, exp_start;
    logic [1:0] m_mode, m_pmode, wm;
    logic [15:0] m_pat, m_prev, exp_p;
    cyc = 0; m_en = -1000; m_cnt0 = 0; m_act = 0; m_pend = 0;
    m_mode = 0; m_pmode = 0; m_pat = 0; m_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_act = 0; m_en = -1000; m_mode = 0; m_pend = 0; m_pmode = 0;
        m_pat = 0; m_prev = 0; m_cnt0 = cyc + 1;
      end else begin
        exp_en    = m_act && (cyc == m_en);
        exp_start = m_act && (cyc == m_en + LAT_GAP);
        exp_p     = (cyc > m_en) ? m_pat : m_prev;
        chk("model_p_data", p_data_o, {16'h0000, exp_p});
        chk("model_en", 32'(en_o), 32'(exp_en));
        chk("model_start", 32'(start_o), 32'(exp_start));
        chk("model_cur_mode", 32'(cur_mode_o), 32'(m_mode));
        en_cnt    += int'(en_o);
        start_cnt += int'(start_o);
        free = !m_act || (cyc > m_en + LAT_GAP);
        tick = ((cyc - m_cnt0) % TICK_DIV) == TICK_DIV - 1;
        if (free && (m_pend || mode_we_i)) begin
          wm = mode_we_i ? mode_i : m_pmode;
          m_mode = wm; m_prev = exp_p; m_pat = init_of(wm);
          m_en = cyc + 1; m_cnt0 = cyc + 1; m_pend = 0; m_act = 1;
        end else begin
          if (mode_we_i) begin
            m_pend = 1; m_pmode = mode_i;
          end
          if (m_act && free && tick && !freeze_i) begin
            m_prev = exp_p; m_pat = next_of(m_mode, m_pat); m_en = cyc + 1;
          end
        end
      end
      cyc++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic do_write(input logic [1:0] m);
    @(posedge clk); #1;
    mode_we_i = 1'b1; mode_i = m;
    @(posedge clk); #1;
    mode_we_i = 1'b0;
  endtask

  // Wait for an en pulse (bounded); returns negedges waited
  task automatic wait_en(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!en_o && n < 40);
    chk("en_seen", 32'(en_o), 32'd1);
  endtask

  // Wait for en, optionally pin the wait length, then pin the loaded pattern
  task automatic step_check(input string nm, input logic [15:0] exp_pat, input int exp_n);
    int n;
    wait_en(n);
    if (exp_n > 0) chk({nm, "_wait"}, 32'(n), 32'(exp_n));
    @(negedge clk);
    chk(nm, p_data_o, {16'h0000, exp_pat});
  endtask

  initial begin : stim
    int n, e0, s0;
    logic [15:0] v;
    rst = 1'b1; mode_we_i = 1'b0; mode_i = 2'd0; freeze_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: nothing happens
    repeat (20) @(posedge clk);
    #1;
    chk("idle_p_data", p_data_o, 32'h0);
    chk("idle_cur_mode", 32'(cur_mode_o), 32'd0);
    chk("idle_en_count", 32'(en_cnt), 32'd0);
    chk("idle_start_count", 32'(start_cnt), 32'd0);

    // SCROLL: en one cycle after the write, start two cycles after en
    do_write(2'd1);
    wait_en(n);
    chk("scroll_latency", 32'(n), 32'd1);
    @(negedge clk);
    chk("scroll_init", p_data_o, 32'h0000_0001);
    @(negedge clk);
    chk("scroll_start", 32'(start_o), 32'd1);
    chk("scroll_mode", 32'(cur_mode_o), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      v = 16'h0001 << (k % 16);
      step_check("scroll_step", v, (k == 1) ? 2 : 3);
    end

    // BAR: fills from bit 0, empties after 0xFFFF, restarts at 0x0001
    do_write(2'd3);
    step_check("bar_init", 16'h0001, 0);
    for (int k = 1; k <= 17; k++) begin
      if (k <= 15) v = 16'((32'd1 << (k + 1)) - 32'd1);
      else if (k == 16) v = 16'h0000;
      else v = 16'h0001;
      step_check("bar_step", v, 3);
    end

    // BLINK with a freeze window after two steps
    do_write(2'd2);
    step_check("blink_init", 16'hFFFF, 0);
    step_check("blink_step", 16'h0000, 3);
    @(posedge clk); #1;
    freeze_i = 1'b1;
    e0 = en_cnt;
    repeat (12) @(posedge clk);
    #1 freeze_i = 1'b0;
    chk("freeze_no_en", 32'(en_cnt - e0), 32'd0);
    step_check("blink_after_freeze", 16'hFFFF, 0);

    // Two back-to-back writes while the step is in flight: last one wins
    wait_en(n);
    @(posedge clk); #1;
    e0 = en_cnt; s0 = start_cnt;
    mode_we_i = 1'b1; mode_i = 2'd1;
    @(posedge clk); #1;
    mode_i = 2'd2;
    @(posedge clk); #1;
    mode_we_i = 1'b0;
    step_check("gap_accept", 16'hFFFF, 2);
    chk("gap_cur_mode", 32'(cur_mode_o), 32'd2);
    @(posedge clk); #1;
    chk("gap_one_en", 32'(en_cnt - e0), 32'd1);
    chk("gap_one_start", 32'(start_cnt - s0), 32'd1);

    // Reset during GAP aborts the step
    wait_en(n);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    e0 = en_cnt; s0 = start_cnt;
    @(negedge clk);
    chk("rst_p_data", p_data_o, 32'h0);
    chk("rst_start", 32'(start_o), 32'd0);
    chk("rst_en", 32'(en_o), 32'd0);
    chk("rst_cur_mode", 32'(cur_mode_o), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_en", 32'(en_cnt - e0), 32'd0);
    chk("rst_no_start", 32'(start_cnt - s0), 32'd0);

    // OFF still emits a step every tick
    do_write(2'd0);
    step_check("off_init", 16'h0000, 1);
    step_check("off_step", 16'h0000, 3);
    chk("off_cur_mode", 32'(cur_mode_o), 32'd0);

    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
